// File: rtl/updn_counter_pkg.sv
// Shared types and defaults for the up/down modulo counter family.
package updn_counter_pkg;

  localparam int CNT_DEFAULT_WIDTH = 6;

  typedef enum logic {
    CNT_SATURATE = 1'b0,
    CNT_WRAP     = 1'b1
  } cnt_mode_e;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } cnt_dir_e;

  // Both or neither request asserted means hold.
  function automatic cnt_dir_e decode_dir(input logic up, input logic down);
    case ({up, down})
      2'b10:   return DIR_UP;
      2'b01:   return DIR_DOWN;
      default: return DIR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/updn_cnt_next.sv
// Next-count and terminal-count logic for one step of the modulo counter.
module updn_cnt_next
  import updn_counter_pkg::*;
#(
  parameter int WIDTH = CNT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  cnt_mode_e        mode_i,
  input  cnt_dir_e         dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic             at_high;
  logic             at_low;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  // A counter above a lowered limit counts as high, so up never overflows.
  assign at_high   = (count_i >= limit_i);
  assign at_low    = (count_i == '0);
  assign count_inc = count_i + WIDTH'(1);
  assign count_dec = count_i - WIDTH'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    count_o = count_i;
    tc_o    = 1'b0;
    case (dir_i)
      DIR_UP: begin
        if (!at_high) begin
          count_o = count_inc;
          tc_o    = (count_inc == limit_i);
        end else if (mode_i == CNT_WRAP) begin
          count_o = '0;
          tc_o    = 1'b1;
        end
      end
      DIR_DOWN: begin
        if (!at_low) begin
          count_o = count_dec;
          tc_o    = (count_dec == '0);
        end else if (mode_i == CNT_WRAP) begin
          count_o = limit_i;
          tc_o    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updn_mod_counter.sv
// Up/down modulo counter with wrap/saturate mode, boundary flags and Tc strobe.
// Define UPDN_CNT_ALMOST_EN to add the Almost_Low / Almost_High outputs.
module updn_mod_counter
  import updn_counter_pkg::*;
#(
  parameter int WIDTH  = CNT_DEFAULT_WIDTH,
  parameter int ALMOST = 1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic [WIDTH-1:0] Limit,
  input  logic             Wrap,
  output logic [WIDTH-1:0] Counter,
  output logic             Low,
  output logic             High,
  output logic             Tc
`ifdef UPDN_CNT_ALMOST_EN
  ,
  output logic             Almost_Low,
  output logic             Almost_High
`endif
);

  if (WIDTH < 2 || ALMOST < 0) begin : g_bad_param
    $error("updn_mod_counter: WIDTH must be >= 2 and ALMOST >= 0");
  end

  logic [WIDTH-1:0] count_q, count_d, step_count;
  logic             tc_q, tc_d, step_tc;
  cnt_mode_e        mode;
  cnt_dir_e         dir;

  assign mode = cnt_mode_e'(Wrap);
  assign dir  = decode_dir(Up, Down);

  updn_cnt_next #(.WIDTH(WIDTH)) u_next (
    .count_i (count_q),
    .limit_i (Limit),
    .mode_i  (mode),
    .dir_i   (dir),
    .count_o (step_count),
    .tc_o    (step_tc)
  );

  // Load wins over a step and clamps into [0, Limit].
  always_comb begin
    count_d = step_count;
    tc_d    = step_tc;
    if (Load) begin
      count_d = (IN < Limit) ? IN : Limit;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign Counter = count_q;
  assign Tc      = tc_q;
  assign Low     = (count_q == '0);
  assign High    = (count_q >= Limit);

`ifdef UPDN_CNT_ALMOST_EN
  // One extra bit keeps Counter + ALMOST from wrapping.
  localparam logic [WIDTH:0] ALMOST_W = (WIDTH + 1)'(ALMOST);

  assign Almost_Low  = ({1'b0, count_q} <= ALMOST_W);
  assign Almost_High = (({1'b0, count_q} + ALMOST_W) >= {1'b0, Limit});
`endif

endmodule
